uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial console receiver: 8N1 UART receive with a built-in 4x-oversampling baud tick generator.
//  Decodes the SoC UART_TXD line into bytes for the simulation console and host-side monitors.
//  The upstream CPU uses byte 0xFF as its halt marker; this block passes 0xFF through as ordinary data.
//  Single clock domain; the baud tick is an enable strobe, never a clock.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency
//  BAUD     115200      line rate
//  OSR      4           samples per bit (fixed; other values unsupported)
//  DIV      CLK_HZ/(BAUD*OSR) (=108)  clocks per tick, integer truncation; tests override it small
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  synchronous, active-high
//  rx         in   1  serial input, idle high, asynchronous to clk
//  tick       out  1  one-clk strobe every DIV clocks (4x baud)
//  rx_byte    out  8  last good received byte, held until the next good frame
//  rdy        out  1  one-clk pulse: rx_byte just updated
//  frame_err  out  1  one-clk pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset: tick=0, rx_byte=8'h00, rdy=0, frame_err=0, FSM=IDLE, divider=0, synchronizer flops=1.
//  Divider: counts 0..DIV-1; tick=1 on the cycle the count wraps to 0; free-running when out of reset.
//  rx passes through 2 flops (rxs) before any use; all samples are taken only on tick cycles.
//  FSM (one transition per tick at most):
//   IDLE : rxs==0 on a tick -> START, cnt=0.
//   START: after 2 further ticks (mid start bit) sample: 0 -> DATA, bit=0, cnt=0; 1 -> IDLE (glitch reject).
//   DATA : every 4th tick sample rxs into shift reg, LSB first; after bit 7 -> STOP.
//   STOP : 4 ticks later sample: 1 -> rx_byte<=shift, rdy pulse; 0 -> frame_err pulse, rx_byte unchanged.
//          Either way -> IDLE the same cycle (mid stop bit), so back-to-back frames are accepted.
//  rdy/frame_err asserted exactly one clk, registered, on the clock after the stop sample tick.
//  In IDLE with line held low after a framing error: a new start is detected immediately (break = repeated frame_err).
//  Reset mid-frame: FSM to IDLE, partial byte dropped, no rdy; rx_byte reset to 0.
//  Latency: rdy rises ~9.5 bit times (+2 clk sync, +1 clk reg) after the start-bit falling edge.
//  Rate error from DIV truncation (<1% at defaults) is tolerated by mid-bit sampling.
// TESTING  (bench uses DIV=4, so one bit = 16 clk; drive rx with ideal 8N1 frames)
//  Reset held 5 clk: rx_byte=0x00, rdy=0, frame_err=0, tick=0; after release tick pulses every 4 clk.
//  Send 0x41 -> exactly one rdy pulse, rx_byte=0x41, frame_err never 1.
//  Send 0xFF then 0x00 back-to-back (no idle gap) -> rdy twice, rx_byte 0xFF then 0x00.
//  Low glitch of 4 clk on idle line -> no rdy, no frame_err, FSM back to IDLE.
//  Send 0x55 with stop bit forced low -> frame_err pulse, no rdy, rx_byte keeps prior value.
//  Assert reset during bit 4 of 0x3C, release, send 0x7E -> only one rdy, rx_byte=0x7E.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 4x-oversampling baud tick generator
module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OSR    = 4,
    parameter int DIV    = CLK_HZ / (BAUD * OSR)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tick,
    output logic [7:0] rx_byte,
    output logic       rdy,
    output logic       frame_err
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, byte_q, byte_d;
    logic          rdy_q, rdy_d, ferr_q, ferr_d;
    logic          tick_q, s1_q, s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        div_d   = (div_q == DW'(DIV - 1)) ? '0 : div_q + 1'b1;
        if (tick_q) begin
            case (state_q)
                IDLE: if (!s2_q) begin
                    state_d = START;
                    cnt_d   = 2'd0;
                end
                START: if (cnt_q == 2'd1) begin
                    state_d = s2_q ? IDLE : DATA;
                    cnt_d   = 2'd0;
                    bit_d   = 3'd0;
                end else cnt_d = cnt_q + 2'd1;
                DATA: if (cnt_q == 2'd3) begin
                    shift_d = {s2_q, shift_q[7:1]};
                    cnt_d   = 2'd0;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end else cnt_d = cnt_q + 2'd1;
                STOP: if (cnt_q == 2'd3) begin
                    // Leave mid stop bit so a following start edge is not missed
                    state_d = IDLE;
                    byte_d  = s2_q ? shift_q : byte_q;
                    rdy_d   = s2_q;
                    ferr_d  = !s2_q;
                end else cnt_d = cnt_q + 2'd1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= 2'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            tick_q  <= 1'b0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            tick_q  <= (div_q == DW'(DIV - 1));
            s1_q    <= rx;
            s2_q    <= s1_q;
        end
    end

    assign tick      = tick_q;
    assign rx_byte   = byte_q;
    assign rdy       = rdy_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx with DIV=4 (16 clk per bit)
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       tick, rdy, frame_err;
    logic [7:0] rx_byte;
    int         vec = 0;
    int         err = 0;
    int         rdy_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] got[$];

    uart_rx #(.DIV(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tick(tick),
        .rx_byte(rx_byte), .rdy(rdy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy) begin
            rdy_cnt++;
            got.push_back(rx_byte);
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        vec++; if (rx_byte !== 8'h00) begin err++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
        vec++; if (rdy !== 1'b0) begin err++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        vec++; if (frame_err !== 1'b0) begin err++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        vec++; if (tick !== 1'b0) begin err++; $display("FAIL reset_tick got=%b exp=0", tick); end
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vec++;
            if (tick !== (i % 4 == 0)) begin
                err++; $display("FAIL tick_cycle%0d got=%b exp=%b", i, tick, (i % 4 == 0));
            end
        end
    endtask

    task automatic test_single;
        int r0 = rdy_cnt, f0 = ferr_cnt;
        send_frame(8'h41, 1'b1);
        repeat (20) @(negedge clk);
        vec++; if (rdy_cnt - r0 !== 1) begin err++; $display("FAIL single_rdy_count got=%0d exp=1", rdy_cnt - r0); end
        vec++; if (rx_byte !== 8'h41) begin err++; $display("FAIL single_byte got=%h exp=41", rx_byte); end
        vec++; if (ferr_cnt - f0 !== 0) begin err++; $display("FAIL single_frame_err got=%0d exp=0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        int r0 = rdy_cnt, q0 = got.size();
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        vec++; if (rdy_cnt - r0 !== 2) begin err++; $display("FAIL b2b_rdy_count got=%0d exp=2", rdy_cnt - r0); end
        vec++; if (got.size() < q0 + 2 || got[q0] !== 8'hFF) begin err++; $display("FAIL b2b_first_byte got=%h exp=ff", (got.size() > q0) ? got[q0] : 8'hxx); end
        vec++; if (got.size() < q0 + 2 || got[q0+1] !== 8'h00) begin err++; $display("FAIL b2b_second_byte got=%h exp=00", (got.size() > q0 + 1) ? got[q0+1] : 8'hxx); end
    endtask

    task automatic test_glitch;
        int r0 = rdy_cnt, f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        vec++; if (rdy_cnt - r0 !== 0) begin err++; $display("FAIL glitch_rdy got=%0d exp=0", rdy_cnt - r0); end
        vec++; if (ferr_cnt - f0 !== 0) begin err++; $display("FAIL glitch_frame_err got=%0d exp=0", ferr_cnt - f0); end
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        vec++; if (rdy_cnt - r0 !== 1) begin err++; $display("FAIL glitch_recover_rdy got=%0d exp=1", rdy_cnt - r0); end
        vec++; if (rx_byte !== 8'hA5) begin err++; $display("FAIL glitch_recover_byte got=%h exp=a5", rx_byte); end
    endtask

    task automatic test_frame_err;
        int r0 = rdy_cnt, f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        vec++; if (ferr_cnt - f0 !== 1) begin err++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        vec++; if (rdy_cnt - r0 !== 0) begin err++; $display("FAIL ferr_rdy got=%0d exp=0", rdy_cnt - r0); end
        vec++; if (rx_byte !== 8'hA5) begin err++; $display("FAIL ferr_byte_held got=%h exp=a5", rx_byte); end
    endtask

    task automatic test_reset_mid_frame;
        int r0 = rdy_cnt;
        logic [7:0] d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (rx_byte !== 8'h00) begin err++; $display("FAIL midreset_byte got=%h exp=00", rx_byte); end
        reset = 1'b0;
        rx = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        repeat (20) @(negedge clk);
        vec++; if (rdy_cnt - r0 !== 1) begin err++; $display("FAIL midreset_rdy_count got=%0d exp=1", rdy_cnt - r0); end
        vec++; if (rx_byte !== 8'h7E) begin err++; $display("FAIL midreset_byte_after got=%h exp=7e", rx_byte); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
